// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI responder.
//   spi_slave_state_t : frame FSM state (IDLE, SHIFT)
//   SPI_DATA_W        : frame width in bits
//   SPI_IDLE_BYTE_DEF : default byte sent when the TX buffer is empty
package spi_pkg;

  localparam int SPI_DATA_W = 8;
  localparam logic [SPI_DATA_W-1:0] SPI_IDLE_BYTE_DEF = 8'h00;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_slave_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: SYNC_STAGES-deep synchronizer for one asynchronous input,
// with one extra registered copy to derive single-cycle edge strobes.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   d_i        : asynchronous input
//   level_o    : synchronized level
//   rise_o     : one-cycle strobe on synchronized 0->1
//   fall_o     : one-cycle strobe on synchronized 1->0
// RST_VAL sets the idle level all flops take in reset.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  if (SYNC_STAGES < 2) begin : g_bad_depth
    $error("spi_sync_edge: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 responder, MSB first, 8-bit frames, oversampled on clk.
// Ports:
//   clk, reset          : system clock, synchronous active-high reset
//   sclk, mosi, ss_n    : SPI pins from the master (asynchronous)
//   miso, miso_oe       : serial data out and pad enable (enable while in a frame)
//   tx_data/valid/ready : one-entry TX byte buffer, accept on valid && ready
//   rx_data, rx_valid   : last complete byte and its one-cycle update pulse
//   busy                : frame in progress
// Optional build macro SPI_SLAVE_ABORT_FLAG_EN adds:
//   abort       : pulse when ss_n deasserts mid-byte
//   tx_underrun : pulse when IDLE_BYTE is loaded because the buffer was empty
module spi_slave
  import spi_pkg::*;
#(
  parameter int                    SYNC_STAGES = 2,
  parameter logic [SPI_DATA_W-1:0] IDLE_BYTE   = SPI_IDLE_BYTE_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  ss_n,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [SPI_DATA_W-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [SPI_DATA_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy
`ifdef SPI_SLAVE_ABORT_FLAG_EN
  ,
  output logic                  abort,
  output logic                  tx_underrun
`endif
);

  localparam int CNT_W = $clog2(SPI_DATA_W);

  // synchronized pins
  logic sclk_s, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic ss_s, ss_rise, ss_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .d_i(sclk),
    .level_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .d_i(mosi),
    .level_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  // ss_n idles high so reset does not fake a frame start
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset(reset), .d_i(ss_n),
    .level_o(ss_s), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  logic unused_strobes;
  assign unused_strobes = sclk_s ^ mosi_rise ^ mosi_fall ^ ss_rise;

  spi_slave_state_t      state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [SPI_DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [SPI_DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [SPI_DATA_W-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic [SPI_DATA_W-1:0] buf_q, buf_d;
  logic                  full_q, full_d;
  logic                  load, accept;
  logic                  abort_d, underrun_d;

  assign accept = tx_valid & ~full_q;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    abort_d    = 1'b0;
    underrun_d = 1'b0;
    load       = 1'b0;

    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (ss_fall) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // deselect wins over any sclk edge in the same cycle
        if (ss_s) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          abort_d   = (bit_cnt_q != '0);
        end else if (sclk_rise) begin
          rx_sh_d   = {rx_sh_q[SPI_DATA_W-2:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_W'(SPI_DATA_W - 1)) begin
            rx_data_d  = {rx_sh_q[SPI_DATA_W-2:0], mosi_s};
            rx_valid_d = 1'b1;
          end
        end else if (sclk_fall) begin
          // fall after a complete byte primes the next back-to-back frame
          if (bit_cnt_q != '0) tx_sh_d = {tx_sh_q[SPI_DATA_W-2:0], 1'b0};
          else                 load    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // load sees the buffer as it was before any same-cycle accept
    if (load) begin
      tx_sh_d    = full_q ? buf_q : IDLE_BYTE;
      underrun_d = ~full_q;
    end

    full_d = (full_q & ~load) | accept;
    buf_d  = accept ? tx_data : buf_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      buf_q      <= '0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      buf_q      <= buf_d;
      full_q     <= full_d;
    end
  end

`ifdef SPI_SLAVE_ABORT_FLAG_EN
  logic abort_q, underrun_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      abort_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      abort_q    <= abort_d;
      underrun_q <= underrun_d;
    end
  end

  assign abort       = abort_q;
  assign tx_underrun = underrun_q;
`else
  logic unused_flags;
  assign unused_flags = abort_d ^ underrun_d;
`endif

  assign busy     = (state_q == SHIFT);
  assign miso     = busy & tx_sh_q[SPI_DATA_W-1];
  assign miso_oe  = busy;
  assign tx_ready = ~full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

  localparam int HALF = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       ss_n = 1'b1;
  logic       miso, miso_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
  logic       abort, tx_underrun;
`endif

  spi_slave dut (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
    .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
`ifdef SPI_SLAVE_ABORT_FLAG_EN
    , .abort(abort), .tx_underrun(tx_underrun)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // pulse counters (cycles high), sampled away from the active edge
  int rxv_cnt = 0;
  int abort_cnt = 0;
  int und_cnt = 0;
  always @(negedge clk) begin
    if (rx_valid === 1'b1) rxv_cnt++;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
    if (abort === 1'b1) abort_cnt++;
    if (tx_underrun === 1'b1) und_cnt++;
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [7:0] b);
    @(posedge clk); #1;
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic frame_start();
    @(posedge clk); #1;
    ss_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // mode-0 master: data set on low half, sampled before the rising edge;
  // when ending the frame, the final sclk fall coincides with ss_n rising
  task automatic xfer(input logic [7:0] d, input int nbits, input bit end_frame,
                      output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = d[7-i];
      repeat (HALF) @(posedge clk);
      #1;
      r = {r[6:0], miso};
      sclk = 1'b1;
      repeat (HALF) @(posedge clk);
      #1;
      sclk = 1'b0;
      if (end_frame && i == nbits - 1) ss_n = 1'b1;
    end
    if (end_frame) begin
      repeat (HALF) @(posedge clk);
      #1;
    end
  endtask

  logic [7:0] mrx, mrx2;
  int p_rx, p_ab, p_un;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_miso", miso, 0);
    check("rst_miso_oe", miso_oe, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_busy", busy, 0);

    // 1: preloaded A5, master sends 3C
    offer(8'hA5);
    check("t1_ready_full", tx_ready, 0);
    p_rx = rxv_cnt;
    frame_start();
    check("t1_ready_start", tx_ready, 1);
    check("t1_busy", busy, 1);
    check("t1_oe", miso_oe, 1);
    xfer(8'h3C, 8, 1'b1, mrx);
    check("t1_master_rx", mrx, 8'hA5);
    check("t1_rx_data", rx_data, 8'h3C);
    check("t1_rxv_pulses", rxv_cnt - p_rx, 1);
    check("t1_busy_end", busy, 0);

    // 2: empty buffer, master sends FF
    p_un = und_cnt;
    frame_start();
    xfer(8'hFF, 8, 1'b1, mrx);
    check("t2_master_rx", mrx, 8'h00);
    check("t2_rx_data", rx_data, 8'hFF);
`ifdef SPI_SLAVE_ABORT_FLAG_EN
    check("t2_underrun", und_cnt - p_un, 1);
`endif

    // 3: two back-to-back frames under one ss_n
    offer(8'h12);
    p_rx = rxv_cnt;
    frame_start();
    offer(8'h34);
    check("t3_ready_refill", tx_ready, 0);
    xfer(8'h81, 8, 1'b0, mrx);
    check("t3_rx_data0", rx_data, 8'h81);
    xfer(8'h7E, 8, 1'b1, mrx2);
    check("t3_master_rx0", mrx, 8'h12);
    check("t3_master_rx1", mrx2, 8'h34);
    check("t3_rx_data1", rx_data, 8'h7E);
    check("t3_rxv_pulses", rxv_cnt - p_rx, 2);

    // 4: abort after 4 bits, then a good frame
    p_rx = rxv_cnt;
    p_ab = abort_cnt;
    frame_start();
    xfer(8'hF0, 4, 1'b1, mrx);
    check("t4_rxv_none", rxv_cnt - p_rx, 0);
    check("t4_rx_hold", rx_data, 8'h7E);
    check("t4_busy", busy, 0);
    check("t4_oe", miso_oe, 0);
    check("t4_miso", miso, 0);
`ifdef SPI_SLAVE_ABORT_FLAG_EN
    check("t4_abort", abort_cnt - p_ab, 1);
`endif
    frame_start();
    xfer(8'hC3, 8, 1'b1, mrx);
    check("t4_rx_after", rx_data, 8'hC3);

    // 5: reset for one cycle after 5 bits
    offer(8'hE7);
    frame_start();
    xfer(8'h6B, 5, 1'b0, mrx);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("t5_miso", miso, 0);
    check("t5_tx_ready", tx_ready, 1);
    check("t5_rx_data", rx_data, 8'h00);
    check("t5_busy", busy, 0);
    check("t5_oe", miso_oe, 0);
    reset = 1'b0;
    ss_n  = 1'b1;
    repeat (HALF) @(posedge clk);
    #1;
    frame_start();
    xfer(8'h5A, 8, 1'b1, mrx);
    check("t5_rx_after", rx_data, 8'h5A);
    check("t5_master_rx", mrx, 8'h00);

    // 6: tx_valid in the same cycle as the frame-start load, buffer empty
    @(posedge clk); #1;
    ss_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    tx_data  = 8'h99;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    check("t6_busy", busy, 1);
    check("t6_buffered", tx_ready, 0);
    xfer(8'h11, 8, 1'b1, mrx);
    check("t6_master_rx0", mrx, 8'h00);
    frame_start();
    check("t6_ready_after", tx_ready, 1);
    xfer(8'h22, 8, 1'b1, mrx);
    check("t6_master_rx1", mrx, 8'h99);
    check("t6_rx_data", rx_data, 8'h22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
